// File: rtl/router_pkg.sv
// Shared constants and the beat bundle for the router ingress path.
package router_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_PORTS  = 4;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int PORT_SEL_W     = $clog2(DEF_NUM_PORTS);
    localparam int STAT_W         = 16;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] data;
    } beat_t;

endpackage

// File: rtl/router_port_fifo.sv
// Per-port beat FIFO: registered count/full, head zeroed when empty.
module router_port_fifo
    import router_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [ADDR_WIDTH-1:0] head_addr,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  empty,
    output logic                  full
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_next;
    logic                  push_ok;
    logic                  pop_ok;

    // Full blocks the push even when the same cycle pops: no bypass.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign empty   = (count == '0);

    always_comb begin
        count_next = count;
        unique case ({push_ok, pop_ok})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == DEPTH_C);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_addr[wr_ptr] <= wr_addr;
            mem_data[wr_ptr] <= wr_data;
        end
    end

    assign head_addr = empty ? '0 : mem_addr[rd_ptr];
    assign head_data = empty ? '0 : mem_data[rd_ptr];

endmodule

// File: rtl/router_dispatch.sv
// Router ingress: decode port from address MSBs, buffer per port.
// Optional ROUTER_DISPATCH_STATS_EN adds per-port push counters.
module router_dispatch
    import router_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [ADDR_WIDTH-1:0]           s_addr,
    input  logic [DATA_WIDTH-1:0]           s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    output logic [NUM_PORTS*ADDR_WIDTH-1:0] m_addr,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] m_data,
    output logic [NUM_PORTS-1:0]            m_valid,
    input  logic [NUM_PORTS-1:0]            m_ready,
    output logic [NUM_PORTS-1:0]            port_full
`ifdef ROUTER_DISPATCH_STATS_EN
    ,
    input  logic                            stat_clear,
    output logic [NUM_PORTS*STAT_W-1:0]     stat_count
`endif
);

    localparam int SEL_W = $clog2(NUM_PORTS);

    logic [SEL_W-1:0]     sel;
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] empty;

    assign sel     = s_addr[ADDR_WIDTH-1 -: SEL_W];
    assign s_ready = !port_full[sel];
    assign m_valid = ~empty;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign push[i] = s_valid && s_ready && (sel == SEL_W'(i));

        router_port_fifo #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (push[i]),
            .wr_addr   (s_addr),
            .wr_data   (s_data),
            .pop       (m_ready[i]),
            .head_addr (m_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .head_data (m_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .empty     (empty[i]),
            .full      (port_full[i])
        );

`ifdef ROUTER_DISPATCH_STATS_EN
        logic [STAT_W-1:0] stat_q;

        // Clear wins over a same-cycle increment; counter wraps freely.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stat_q <= '0;
            end else if (stat_clear) begin
                stat_q <= '0;
            end else if (push[i]) begin
                stat_q <= stat_q + 1'b1;
            end
        end

        assign stat_count[i*STAT_W +: STAT_W] = stat_q;
`endif
    end

endmodule

// File: doc/router_dispatch.md
# router_dispatch

Ingress stage of the 1x4 router: accepts a single address/data stream with a valid/ready handshake, decodes the destination port from the address MSBs, and buffers each beat in a per-port FIFO. It presents per-port address/data/valid lanes in the packed layout the 4-port router core consumes. The block sits directly upstream of the router core and absorbs per-port backpressure.

## Interface
- ADDR_WIDTH, 32, address width per beat
- DATA_WIDTH, 32, data width per beat
- NUM_PORTS, 4, output lanes; power of two, ≥2
- FIFO_DEPTH, 4, entries per port FIFO; power of two, ≥2

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- s_addr  in  ADDR_WIDTH  ingress address
- s_data  in  DATA_WIDTH  ingress data
- s_valid  in  1  ingress beat valid
- s_ready  out  1  ingress beat accepted when s_valid && s_ready
- m_addr  out  NUM_PORTS*ADDR_WIDTH  per-port head address; lane i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_data  out  NUM_PORTS*DATA_WIDTH  per-port head data; lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- m_valid  out  NUM_PORTS  per-port FIFO non-empty
- m_ready  in  NUM_PORTS  per-port pop enable; tie high when the consumer has no backpressure
- port_full  out  NUM_PORTS  per-port FIFO full flag

## Operation
- Port select: sel = s_addr[ADDR_WIDTH-1 -: log2(NUM_PORTS)]; every address maps to exactly one port.
- s_ready = !port_full[sel]; combinational from s_addr and registered FIFO state, never from s_valid or m_ready.
- Push: s_valid && s_ready writes {s_addr, s_data} into FIFO[sel]; wr pointer advances, wraps at FIFO_DEPTH-1 -> 0.
- Pop: m_valid[i] && m_ready[i] advances FIFO[i] rd pointer with the same wrap rule.
- m_valid[i] = count[i] != 0. m_addr/m_data lanes show the head entry while valid and are forced to 0 while empty.
- Simultaneous push and pop on the same port: count is unchanged, and both pointers advance.
- Full port: no push even if the same port pops in that cycle (no bypass); s_ready is low.
- Head-of-line blocking: a beat for a full port stalls the stream, and later beats for other ports wait. This is intended.
- Ports are independent; pops on all ports may occur in the same cycle.
- Beat order is preserved per port. No ordering guarantee across ports.
- Reset (any time, including mid-transfer): all counts and pointers return to 0; contents are discarded. m_valid=0, m_addr=0, m_data=0, port_full=0, s_ready=1.

## Timing
- Latency: a beat accepted at edge N is visible on m_valid/m_addr/m_data after edge N (cycle N+1). There is no combinational s_* -> m_* path.
- Throughput: 1 beat/cycle ingress; 1 beat/cycle per port egress.
- port_full[i] is registered and asserts in the cycle after the push that reaches FIFO_DEPTH. It deasserts in the cycle after the pop that leaves FIFO_DEPTH-1.
- m_ready affects state only at the clock edge.

## Configuration
- ROUTER_DISPATCH_STATS_EN defined: adds input stat_clear (1) and output stat_count (NUM_PORTS*16).
  - Lane i counts accepted pushes to port i and wraps 16'hFFFF -> 0.
  - stat_clear zeroes all lanes at the next edge and takes priority over a same-cycle increment.
  - Counts reset to 0.
- ROUTER_DISPATCH_STATS_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package router_pkg holds:
  - default ADDR_WIDTH, DATA_WIDTH and NUM_PORTS constants;
  - PORT_SEL_W = log2(NUM_PORTS);
  - STAT_W = 16;
  - beat struct {addr, data}.
- Sub-module router_port_fifo, instantiated NUM_PORTS times:
  - synchronous FIFO with count, full and empty;
  - head output zero-gated when empty;
  - same reset.
- router_dispatch contains the decode, s_ready mux, lane packing and optional stats.

## Test plan
- Reset then single beat: s_addr=32'h4000_0010, s_data=32'hA5A5_0001 -> one cycle later m_valid=4'b0010, lane 1 shows that addr/data; all other lanes are 0.
- Fill port 3 with m_ready=0: 4 beats addr 32'hC000_000x -> port_full[3]=1. A 5th beat for port 3 sees s_ready=0, and a beat for port 0 queued behind it also waits.
- Full port 3, m_ready[3]=1 and s_valid for port 3 in the same cycle -> pop occurs, push is refused; next cycle count=3, s_ready=1.
- Interleaved streams to ports 0 and 2 with m_ready=4'b1111 and 1-beat/cycle ingress -> per-port order preserved; each beat appears exactly one cycle after acceptance.
- Reset asserted with 2 entries queued on each port -> m_valid=0, m_data=0, port_full=0 immediately (asynchronous). After release the FIFOs are empty and s_ready=1.
- With ROUTER_DISPATCH_STATS_EN: 65537 pushes to port 0 -> stat_count lane 0 = 1. stat_clear asserted together with a push -> lane 0 = 0.
